// File: rtl/hazard_sched.sv
// Hazard scheduler for the ID/EX stage: forwarding selects, load-use stalls,
// branch flush sequencing and saturating debug counters for both events.
module hazard_sched #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [4:0]       id_rd,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             branch_taken,
  output logic             fwd_ex_1,
  output logic             fwd_mem_1,
  output logic             fwd_ex_2,
  output logic             fwd_mem_2,
  output logic             stall,
  output logic             clear,
  output logic             flush_if,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned FCNT_W = 3;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [0:0] {ST_RUN, ST_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               ex_v_q, ex_rw_q, ex_mr_q;
  logic [REG_W-1:0]   ex_rd_q;
  logic               mem_v_q, mem_rw_q;
  logic [REG_W-1:0]   mem_rd_q;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic hit_ex_1, hit_ex_2, hit_mem_1, hit_mem_2, load_use;
  logic stall_c, clear_c, flush_c, flush_evt_c;

  // Operand match against the shadowed EX/MEM writers; a load in EX cannot forward yet
  always_comb begin
    hit_ex_1  = ex_v_q & ex_rw_q & ~ex_mr_q & (ex_rd_q != '0) & (ex_rd_q == id_rs1) & id_use1;
    hit_ex_2  = ex_v_q & ex_rw_q & ~ex_mr_q & (ex_rd_q != '0) & (ex_rd_q == id_rs2) & id_use2;
    hit_mem_1 = mem_v_q & mem_rw_q & (mem_rd_q != '0) & (mem_rd_q == id_rs1) & id_use1;
    hit_mem_2 = mem_v_q & mem_rw_q & (mem_rd_q != '0) & (mem_rd_q == id_rs2) & id_use2;
    load_use  = ex_v_q & ex_mr_q & (ex_rd_q != '0) & id_valid &
                ((id_use1 & (id_rs1 == ex_rd_q)) | (id_use2 & (id_rs2 == ex_rd_q)));
  end

  // Stall/flush sequencer: branch beats load-use, flush window restarts on a new branch
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_c     = 1'b0;
    clear_c     = 1'b0;
    flush_c     = 1'b0;
    flush_evt_c = 1'b0;
    if (!rst) begin
      clear_c = 1'b1;
      flush_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            state_d     = ST_FLUSH;
            fcnt_d      = FCNT_W'(FLUSH_CYCLES - 1);
            clear_c     = 1'b1;
            flush_c     = 1'b1;
            flush_evt_c = 1'b1;
          end else if (load_use) begin
            stall_c = 1'b1;
            clear_c = 1'b1;
          end
        end
        ST_FLUSH: begin
          clear_c = 1'b1;
          flush_c = 1'b1;
          if (branch_taken) begin
            fcnt_d      = FCNT_W'(FLUSH_CYCLES - 1);
            flush_evt_c = 1'b1;
          end else if (fcnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State, pipeline shadow and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      ex_v_q      <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      mem_v_q     <= ex_v_q;
      mem_rd_q    <= ex_rd_q;
      mem_rw_q    <= ex_rw_q;
      if (clear_c || !id_valid) begin
        ex_v_q  <= 1'b0;
        ex_rd_q <= '0;
        ex_rw_q <= 1'b0;
        ex_mr_q <= 1'b0;
      end else begin
        ex_v_q  <= 1'b1;
        ex_rd_q <= id_rd;
        ex_rw_q <= id_RegWrite;
        ex_mr_q <= id_MemRead;
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Output drive; a bubble never carries a forwarding select
  always_comb begin
    fwd_ex_1  = hit_ex_1 & ~clear_c;
    fwd_ex_2  = hit_ex_2 & ~clear_c;
    fwd_mem_1 = hit_mem_1 & ~hit_ex_1 & ~clear_c;
    fwd_mem_2 = hit_mem_2 & ~hit_ex_2 & ~clear_c;
    stall     = stall_c;
    clear     = clear_c;
    flush_if  = flush_c;
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: reset, forwarding, load-use, branch flush, saturation.
module tb_hazard_sched;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_use1, id_use2, id_RegWrite, id_MemRead;
  logic             branch_taken;
  logic             fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2;
  logic             stall, clear, flush_if;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  hazard_sched #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .branch_taken(branch_taken),
    .fwd_ex_1(fwd_ex_1), .fwd_mem_1(fwd_mem_1), .fwd_ex_2(fwd_ex_2), .fwd_mem_2(fwd_mem_2),
    .stall(stall), .clear(clear), .flush_if(flush_if),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use1 = u1; id_use2 = u2;
    id_rd = rd; id_RegWrite = rw; id_MemRead = mr;
  endtask

  task automatic test_reset();
    rst = 1'b0; branch_taken = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    total++; if (clear !== 1'b1) $display("FAIL rst_clear got %b exp 1", clear); else passed++;
    total++; if (flush_if !== 1'b1) $display("FAIL rst_flush_if got %b exp 1", flush_if); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall); else passed++;
    total++; if ({fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2} !== 4'b0000)
      $display("FAIL rst_fwd got %b exp 0000", {fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2}); else passed++;
    total++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
      $display("FAIL rst_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); else passed++;
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if ({fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2} !== 4'b0000)
      $display("FAIL post_rst_fwd got %b exp 0000", {fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2}); else passed++;
    total++; if (clear !== 1'b0 || flush_if !== 1'b0)
      $display("FAIL post_rst_run clear/flush got %b%b exp 00", clear, flush_if); else passed++;
    tick();
  endtask

  task automatic test_ex_fwd();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
    tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x5
    @(negedge clk);
    total++; if ({fwd_ex_1, fwd_ex_2} !== 2'b11)
      $display("FAIL ex_fwd got %b exp 11", {fwd_ex_1, fwd_ex_2}); else passed++;
    total++; if ({fwd_mem_1, fwd_mem_2, stall} !== 3'b000)
      $display("FAIL ex_fwd_mem_stall got %b exp 000", {fwd_mem_1, fwd_mem_2, stall}); else passed++;
    tick();
  endtask

  task automatic test_priority();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);   // writes x7 (goes to MEM)
    tick();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);   // writes x7 (sits in EX)
    tick();
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // reads x7
    @(negedge clk);
    total++; if ({fwd_ex_1, fwd_mem_1} !== 2'b10)
      $display("FAIL prio_1 got %b exp 10", {fwd_ex_1, fwd_mem_1}); else passed++;
    total++; if ({fwd_ex_2, fwd_mem_2} !== 2'b10)
      $display("FAIL prio_2 got %b exp 10", {fwd_ex_2, fwd_mem_2}); else passed++;
    tick();
    set_id(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);   // EX=x8, MEM=x7
    @(negedge clk);
    total++; if ({fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2} !== 4'b0100)
      $display("FAIL mem_only got %b exp 0100", {fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2}); else passed++;
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);   // writes x0
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);   // writes x0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);   // reads x0 twice
    @(negedge clk);
    total++; if ({fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2} !== 4'b0000)
      $display("FAIL x0_fwd got %b exp 0000", {fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2}); else passed++;
    tick();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
    tick();
    set_id(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // add x4,x3,x1
    @(negedge clk);
    total++; if ({stall, clear, flush_if} !== 3'b110)
      $display("FAIL lu_stall got %b exp 110", {stall, clear, flush_if}); else passed++;
    total++; if ({fwd_ex_1, fwd_mem_1, stall_cnt} !== {2'b00, 4'd0})
      $display("FAIL lu_fwd_cnt got %b exp 000000", {fwd_ex_1, fwd_mem_1, stall_cnt}); else passed++;
    tick();
    @(negedge clk);
    total++; if ({stall, clear} !== 2'b00)
      $display("FAIL lu_release got %b exp 00", {stall, clear}); else passed++;
    total++; if ({fwd_ex_1, fwd_mem_1, fwd_mem_2} !== 3'b010)
      $display("FAIL lu_memfwd got %b exp 010", {fwd_ex_1, fwd_mem_1, fwd_mem_2}); else passed++;
    total++; if (stall_cnt !== 4'd1) $display("FAIL lu_cnt got %0d exp 1", stall_cnt); else passed++;
    tick();
  endtask

  task automatic test_branch();
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);   // lw x9
    tick();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);   // uses x9, same cycle as branch
    branch_taken = 1'b1;
    @(negedge clk);
    total++; if ({stall, clear, flush_if} !== 3'b011)
      $display("FAIL br_c0 got %b exp 011", {stall, clear, flush_if}); else passed++;
    tick();
    branch_taken = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++; if ({stall, clear, flush_if} !== 3'b011)
      $display("FAIL br_c1 got %b exp 011", {stall, clear, flush_if}); else passed++;
    total++; if (flush_cnt !== 4'd1) $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); else passed++;
    tick();
    @(negedge clk);
    total++; if ({stall, clear, flush_if} !== 3'b011)
      $display("FAIL br_c2 got %b exp 011", {stall, clear, flush_if}); else passed++;
    tick();
    @(negedge clk);
    total++; if ({stall, clear, flush_if} !== 3'b000)
      $display("FAIL br_done got %b exp 000", {stall, clear, flush_if}); else passed++;
    total++; if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1)
      $display("FAIL br_cnts got %0d/%0d exp 1/1", stall_cnt, flush_cnt); else passed++;
    tick();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    for (int i = 0; i < 19; i++) begin
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1); // lw x3
      tick();
      set_id(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0); // add x4,x3,x1
      exp_cnt = (1 + i > 15) ? 15 : 1 + i;
      @(negedge clk);
      total++; if (stall !== 1'b1 || stall_cnt !== 4'(exp_cnt))
        $display("FAIL sat_iter%0d stall/cnt got %b/%0d exp 1/%0d", i, stall, stall_cnt, exp_cnt); else passed++;
      tick();
    end
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d exp 15", stall_cnt); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_priority();
    test_load_use();
    test_branch();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
